// File: rtl/log2_seq_unit.sv
// -----------------------------------------------------------------------------
// log2_seq_unit
//
// Multi-cycle integer log2 engine for run-time sizing of buffers and counters.
// It is the run-time counterpart of a compile-time clog2. A shift register
// is loaded on accept and shifted right once per cycle until it is empty. The
// number of shifts is the answer.
//
// Modes (in_mode):
//   0 CEIL  : ceil(log2 value), 0 and 1 both give 0
//   1 FLOOR : floor(log2 value), 0 gives 0
//   2 RANGE : bits needed to represent value, minimum 1
//   3       : reserved; the result is forced to 0 and out_err is set
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset; drops any job in flight
//   clear      synchronous abort; returns to IDLE and discards the result
//   in_valid   request valid
//   in_ready   request accepted when in_valid && in_ready (IDLE only)
//   in_value   WIDTH-bit unsigned operand, sampled on accept only
//   in_mode    2-bit mode, sampled on accept only
//   out_valid  result valid; held until out_ready
//   out_ready  result consumed when out_valid && out_ready
//   out_result RES_W-bit log2 result, holds 0..WIDTH
//   out_zero   operand was 0 (any mode)
//   out_err    mode was 3
//
// Timing: accept in cycle N, CALC for r+1 cycles (r = number of shifts),
// out_valid first high in cycle N+r+2. in_ready is low outside IDLE, so
// an accept and a result handshake never happen in the same cycle.
// -----------------------------------------------------------------------------
module log2_seq_unit #(
    parameter int WIDTH = 32,
    parameter int RES_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_result,
    output logic             out_zero,
    output logic             out_err
);

    localparam logic [1:0] MODE_CEIL  = 2'd0;
    localparam logic [1:0] MODE_FLOOR = 2'd1;
    localparam logic [1:0] MODE_RANGE = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic             accept_s;
    logic             in_ready_s;
    logic [WIDTH-1:0] v_r;
    logic [RES_W-1:0] cnt_r;
    logic [1:0]       mode_r;
    logic             zero_r;
    logic             err_r;
    logic [RES_W-1:0] result_s;
    logic             out_valid_r;
    logic [RES_W-1:0] out_result_r;
    logic             out_zero_r;
    logic             out_err_r;

    // Initial shift-register contents for each mode. The number of right
    // shifts needed to empty this value is the mode's answer.
    // CEIL avoids the value-1 wrap by mapping 0 straight to 0.
    function automatic logic [WIDTH-1:0] load_value(
        input logic [WIDTH-1:0] value,
        input logic [1:0]       mode
    );
        logic [WIDTH-1:0] v_f;
        v_f = {WIDTH{1'b0}};
        case (mode)
            MODE_CEIL: begin
                if (value == {WIDTH{1'b0}}) begin
                    v_f = {WIDTH{1'b0}};
                end else begin
                    v_f = value - {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            MODE_FLOOR: v_f = value >> 1;
            MODE_RANGE: v_f = value;
            MODE_RSVD:  v_f = {WIDTH{1'b0}};
            default:    v_f = {WIDTH{1'b0}};
        endcase
        return v_f;
    endfunction

    // Ready only in IDLE and not while clear is high, because clear wins
    // over accept. The extra gating on rst_n keeps in_ready low during reset.
    assign in_ready_s = (state_r == ST_IDLE) && !clear;
    assign in_ready   = in_ready_s && rst_n;

    // Result selection: a reserved mode forces 0. RANGE reports at least one
    // bit, so operand 0 still needs 1 bit.
    always_comb begin
        result_s = cnt_r;
        if (err_r) begin
            result_s = {RES_W{1'b0}};
        end else if ((mode_r == MODE_RANGE) && (cnt_r == {RES_W{1'b0}})) begin
            result_s = {{(RES_W-1){1'b0}}, 1'b1};
        end else begin
            result_s = cnt_r;
        end
    end

    // Next-state logic and the accept strobe. Clear overrides all other state changes.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        if (clear) begin
            state_s  = ST_IDLE;
            accept_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_s) begin
                        accept_s = 1'b1;
                        state_s  = ST_CALC;
                    end else begin
                        state_s  = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (v_r == {WIDTH{1'b0}}) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_CALC;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: operand capture, shift/count loop and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_r          <= {WIDTH{1'b0}};
            cnt_r        <= {RES_W{1'b0}};
            mode_r       <= 2'd0;
            zero_r       <= 1'b0;
            err_r        <= 1'b0;
            out_valid_r  <= 1'b0;
            out_result_r <= {RES_W{1'b0}};
            out_zero_r   <= 1'b0;
            out_err_r    <= 1'b0;
        end else if (clear) begin
            out_valid_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        v_r    <= load_value(in_value, in_mode);
                        cnt_r  <= {RES_W{1'b0}};
                        mode_r <= in_mode;
                        zero_r <= (in_value == {WIDTH{1'b0}});
                        err_r  <= (in_mode == MODE_RSVD);
                    end else begin
                        v_r    <= v_r;
                    end
                end
                ST_CALC: begin
                    // cnt cannot pass WIDTH: v holds at most WIDTH set bit positions.
                    if (v_r != {WIDTH{1'b0}}) begin
                        v_r   <= v_r >> 1;
                        cnt_r <= cnt_r + {{(RES_W-1){1'b0}}, 1'b1};
                    end else begin
                        out_valid_r  <= 1'b1;
                        out_result_r <= result_s;
                        out_zero_r   <= zero_r;
                        out_err_r    <= err_r;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_zero   = out_zero_r;
    assign out_err    = out_err_r;

endmodule

// File: tb/tb_log2_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_log2_seq_unit
//
// Directed bench for log2_seq_unit with WIDTH=32. Expected results and
// latencies are computed by hand from the operand values.
// -----------------------------------------------------------------------------
module tb_log2_seq_unit;

    localparam int WIDTH = 32;
    localparam int RES_W = 6;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_value;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_result;
    logic             out_zero;
    logic             out_err;

    int checks   = 0;
    int failures = 0;

    log2_seq_unit #(.WIDTH(WIDTH), .RES_W(RES_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_value   (in_value),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_err    (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, present one request for one accepting edge,
    // then scramble the inputs to prove they are sampled only on accept.
    task automatic issue(input string tag, input logic [31:0] val, input logic [1:0] mode);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_value = val;
        in_mode  = mode;
        tick();
        in_valid = 1'b0;
        in_value = 32'hDEAD_BEEF;
        in_mode  = 2'd3;
    endtask

    // Called just after the accepting edge. lat counts cycles from the accept cycle.
    task automatic expect_result(input string tag, input int exp_res, input logic exp_zero,
                                 input logic exp_err, input int exp_lat);
        int lat;
        lat = 1;
        while (!out_valid && lat < WIDTH + 20) begin
            tick();
            lat++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, 64'(out_result), 64'(exp_res));
        check({tag, "_zero"}, 64'(out_zero), 64'(exp_zero));
        check({tag, "_err"}, 64'(out_err), 64'(exp_err));
        check({tag, "_busy"}, 64'(in_ready), 64'd0);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run(input string tag, input logic [31:0] val, input logic [1:0] mode,
                       input int exp_res, input logic exp_zero, input logic exp_err,
                       input int exp_lat);
        issue(tag, val, mode);
        expect_result(tag, exp_res, exp_zero, exp_err, exp_lat);
        consume(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_value  = 32'd0;
        in_mode   = 2'd0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_zero", 64'(out_zero), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 64'(in_ready), 64'd1);

        // CEIL
        run("ceil_1",    32'd1,         2'd0, 0,  1'b0, 1'b0, 2);
        run("ceil_5",    32'd5,         2'd0, 3,  1'b0, 1'b0, 5);
        run("ceil_0",    32'd0,         2'd0, 0,  1'b1, 1'b0, 2);
        run("ceil_max",  32'hFFFF_FFFF, 2'd0, 32, 1'b0, 1'b0, 34);
        // FLOOR
        run("floor_1",   32'd1,         2'd1, 0,  1'b0, 1'b0, 2);
        run("floor_5",   32'd5,         2'd1, 2,  1'b0, 1'b0, 4);
        run("floor_msb", 32'h8000_0000, 2'd1, 31, 1'b0, 1'b0, 33);
        run("floor_0",   32'd0,         2'd1, 0,  1'b1, 1'b0, 2);
        // RANGE
        run("range_0",   32'd0,         2'd2, 1,  1'b1, 1'b0, 2);
        run("range_1",   32'd1,         2'd2, 1,  1'b0, 1'b0, 3);
        run("range_255", 32'd255,       2'd2, 8,  1'b0, 1'b0, 10);
        run("range_256", 32'd256,       2'd2, 9,  1'b0, 1'b0, 11);
        run("range_max", 32'hFFFF_FFFF, 2'd2, 32, 1'b0, 1'b0, 34);
        // Reserved mode
        run("rsvd_1234", 32'd1234,      2'd3, 0,  1'b0, 1'b1, 2);
        run("rsvd_0",    32'd0,         2'd3, 0,  1'b1, 1'b1, 2);

        // Backpressure: hold result for 10 cycles, then back-to-back accept
        issue("bp", 32'd5, 2'd0);
        expect_result("bp", 3, 1'b0, 1'b0, 5);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_result", 64'(out_result), 64'd3);
            check("bp_hold_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b1;
        in_value  = 32'd256;
        in_mode   = 2'd2;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_hs_valid", 64'(out_valid), 64'd0);
        check("bp_hs_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        in_value = 32'hDEAD_BEEF;
        in_mode  = 2'd3;
        check("bp_next_accepted", 64'(in_ready), 64'd0);
        expect_result("bp_next", 9, 1'b0, 1'b0, 11);
        consume("bp_next");

        // Abort by reset during CALC
        issue("rst_abort", 32'h8000_0000, 2'd1);
        repeat (3) tick();
        check("rst_abort_busy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("rst_abort_in_rst_ready", 64'(in_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_abort_valid", 64'(out_valid), 64'd0);
        check("rst_abort_ready", 64'(in_ready), 64'd1);
        check("rst_abort_result", 64'(out_result), 64'd0);
        run("after_rst", 32'd5, 2'd0, 3, 1'b0, 1'b0, 5);

        // Abort by clear during CALC
        issue("clr_abort", 32'h8000_0000, 2'd1);
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        check("clr_abort_valid", 64'(out_valid), 64'd0);
        check("clr_abort_ready", 64'(in_ready), 64'd1);
        run("after_clr", 32'd5, 2'd0, 3, 1'b0, 1'b0, 5);

        // clear wins over out_ready and over a pending request
        issue("clr_done", 32'd255, 2'd2);
        expect_result("clr_done", 8, 1'b0, 1'b0, 10);
        clear     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_value  = 32'd5;
        in_mode   = 2'd0;
        tick();
        clear     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        check("clr_done_valid", 64'(out_valid), 64'd0);
        check("clr_done_no_accept", 64'(in_ready), 64'd1);
        run("after_clr_done", 32'd1, 2'd2, 1, 1'b0, 1'b0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
